// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider slice.
//   div_state_t    : divider FSM states (IDLE, RUN, DONE)
//   DIV_WIDTH      : default operand width
//   DIV0_QUOTIENT  : quotient reported when dividing by zero (all ones)
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH = 32;

    localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle between a divider client and seq_divider.
//   start, dividend, divisor               : client -> divider
//   busy, ready, div_by_zero,
//   quotient, remainder                    : divider -> client
// master = client side, slave = divider side.
interface seq_divider_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             ready;
    logic             div_by_zero;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start, dividend, divisor,
        input  busy, ready, div_by_zero, quotient, remainder
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, ready, div_by_zero, quotient, remainder
    );

endinterface

// File: rtl/div_remainder_reg.sv
// Combined {remainder, quotient} shift register of the restoring divider.
//   clk, rst   : clock, asynchronous active-high reset (clears the register)
//   load       : start a division, REM <= {0, dividend}
//   load_div0  : divide-by-zero result, REM <= {dividend, all ones}
//   step       : one restoring iteration against dvr
//   dividend   : operand captured by load / load_div0
//   dvr        : registered divisor
//   rem        : register contents; upper half remainder, lower half quotient
module div_remainder_reg
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               load_div0,
    input  logic               step,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   dvr,
    output logic [2*WIDTH-1:0] rem
);

    logic [2*WIDTH-1:0] rem_reg;
    logic [2*WIDTH-1:0] rem_next;
    logic [WIDTH:0]     s_part;
    logic [WIDTH:0]     t_part;

    // The shifted partial remainder keeps the bit that falls out of the top
    // (bit W), so a partial remainder >= 2^(W-1) still compares correctly.
    assign s_part = rem_reg[2*WIDTH-1:WIDTH-1];
    assign t_part = s_part - {1'b0, dvr};

    always_comb begin
        rem_next = rem_reg;
        if (load) begin
            rem_next = {{WIDTH{1'b0}}, dividend};
        end else if (load_div0) begin
            rem_next = {dividend, {WIDTH{DIV0_QUOTIENT[0]}}};
        end else if (step) begin
            // Non-negative difference: keep it and shift in a quotient 1;
            // otherwise restore the shifted value and shift in a 0.
            if (!t_part[WIDTH]) begin
                rem_next = {t_part[WIDTH-1:0], rem_reg[WIDTH-2:0], 1'b1};
            end else begin
                rem_next = {s_part[WIDTH-1:0], rem_reg[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_reg <= '0;
        end else begin
            rem_reg <= rem_next;
        end
    end

    assign rem = rem_reg;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : seq_divider_if slave port
//              start/dividend/divisor in; busy/ready/div_by_zero/quotient/remainder out
// The FSM, iteration counter and divisor register live here; the
// remainder/quotient shift register is div_remainder_reg.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_t         state_reg;
    div_state_t         state_next;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   count_next;
    logic [WIDTH-1:0]   dvr_reg;
    logic [WIDTH-1:0]   dvr_next;
    logic               dz_reg;
    logic               dz_next;

    logic               accept;
    logic               divisor_zero;
    logic               busy;
    logic               ready;
    logic               load;
    logic               load_div0;
    logic               step;
    logic [2*WIDTH-1:0] rem;

    // start is only honoured outside RUN; operands are sampled on that edge.
    assign accept       = bus.start && ((state_reg == IDLE) || (state_reg == DONE));
    assign divisor_zero = (bus.divisor == '0);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            count_reg <= '0;
            dvr_reg   <= '0;
            dz_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            dvr_reg   <= dvr_next;
            dz_reg    <= dz_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        dvr_next   = dvr_reg;
        dz_next    = dz_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (accept) begin
                    if (divisor_zero) begin
                        state_next = DONE;
                        dz_next    = 1'b1;
                    end else begin
                        state_next = RUN;
                        count_next = CNT_W'(WIDTH);
                        dvr_next   = bus.divisor;
                        dz_next    = 1'b0;
                    end
                end
            end
            RUN: begin
                count_next = count_reg - CNT_W'(1);
                // count==1 means this edge performs the last iteration.
                if (count_reg == CNT_W'(1)) begin
                    state_next = DONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs and datapath strobes
    always_comb begin
        busy      = (state_reg == RUN);
        ready     = (state_reg == DONE);
        step      = (state_reg == RUN);
        load      = accept && !divisor_zero;
        load_div0 = accept && divisor_zero;
    end

    div_remainder_reg #(
        .WIDTH(WIDTH)
    ) u_rem (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_div0 (load_div0),
        .step      (step),
        .dividend  (bus.dividend),
        .dvr       (dvr_reg),
        .rem       (rem)
    );

    assign bus.busy        = busy;
    assign bus.ready       = ready;
    assign bus.div_by_zero = dz_reg;
    assign bus.quotient    = rem[WIDTH-1:0];
    assign bus.remainder   = rem[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_seq_divider.sv
// Directed and random bench for seq_divider with a queue-based scoreboard.
module tb_seq_divider;
    import div_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample 1 time unit after the edge, and check that
    // busy and ready are never both high.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        checks++;
        assert (!(bus.busy === 1'b1 && bus.ready === 1'b1)) else begin
            errors++;
            $error("FAIL exclusive busy=%0b ready=%0b", bus.busy, bus.ready);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dz  = 1'b1;
            e.lat = 0;
        end else begin
            e.q   = a / b;
            e.r   = a % b;
            e.dz  = 1'b0;
            e.lat = W;
        end
        return e;
    endfunction

    // Drive start for one cycle. When the request should be accepted, push the
    // expected result and restart the latency counter at the accepting edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit expect_accept);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        tick();
        bus.start    = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
        if (expect_accept) begin
            sb.push_back(model(a, b));
            cyc = 0;
        end
    endtask

    task automatic wait_result(input string tag);
        exp_t e;
        int   n;
        n = 0;
        while (bus.ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check({tag, " ready"}, 64'(bus.ready), 64'd1);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, " latency"},   64'(cyc),             64'(e.lat));
            check({tag, " quotient"},  64'(bus.quotient),    64'(e.q));
            check({tag, " remainder"}, 64'(bus.remainder),   64'(e.r));
            check({tag, " div0"},      64'(bus.div_by_zero), 64'(e.dz));
            check({tag, " busy"},      64'(bus.busy),        64'd0);
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, " busy"},      64'(bus.busy),        64'd0);
        check({tag, " ready"},     64'(bus.ready),       64'd0);
        check({tag, " div0"},      64'(bus.div_by_zero), 64'd0);
        check({tag, " quotient"},  64'(bus.quotient),    64'd0);
        check({tag, " remainder"}, 64'(bus.remainder),   64'd0);
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           sel;

        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        // Reset state
        rst = 1'b1;
        repeat (2) tick();
        check_cleared("reset");
        rst = 1'b0;
        tick();
        check_cleared("idle");

        // 1: basic division
        issue(32'd100, 32'd7, 1'b1);
        wait_result("t1_100_7");

        // 2: extremes, including a partial remainder that needs the carry bit
        issue(32'hFFFF_FFFF, 32'd1, 1'b1);
        wait_result("t2_max_1");
        issue(32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        wait_result("t2_carry");

        // 3: divide by zero
        issue(32'd5, 32'd0, 1'b1);
        wait_result("t3_div0");

        // 4: dividend < divisor, then restart straight out of DONE
        issue(32'd3, 32'd10, 1'b1);
        wait_result("t4_3_10");
        issue(32'd50, 32'd5, 1'b1);
        check("t4 ready_drop", 64'(bus.ready), 64'd0);
        check("t4 busy_rise",  64'(bus.busy),  64'd1);
        wait_result("t4_50_5");

        // 5: start while busy is ignored
        issue(32'd7, 32'd2, 1'b1);
        repeat (9) tick();
        check("t5 busy_before", 64'(bus.busy), 64'd1);
        issue(32'd9, 32'd3, 1'b0);
        check("t5 busy_after", 64'(bus.busy), 64'd1);
        wait_result("t5_7_2");

        // 6: asynchronous reset in the middle of a run
        issue(32'd1000, 32'd3, 1'b1);
        repeat (16) tick();
        rst = 1'b1;
        #1;
        check_cleared("t6_async");
        void'(sb.pop_back());
        tick();
        rst = 1'b0;
        tick();
        check_cleared("t6_idle");
        issue(32'd1000, 32'd3, 1'b1);
        wait_result("t6_1000_3");

        // Random pairs, with zero, small and large divisors mixed in
        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 9);
            a   = $urandom;
            case (sel)
                0:       b = '0;
                1, 2, 3: b = W'($urandom_range(1, 255));
                4:       b = 32'h8000_0000 | W'($urandom);
                5:       begin a = W'($urandom_range(0, 1000)); b = $urandom; end
                default: b = $urandom;
            endcase
            issue(a, b, 1'b1);
            wait_result($sformatf("rnd%0d_%0h_%0h", i, a, b));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
